// File: rtl/psum_collector.sv
// Collects per-row partial sums into a first-word fall-through FIFO tagged with the row index.
// Optional build macro PSUM_ZERO_SKIP_EN drops accepted rows whose psum is +0 or -0.
module psum_collector #(
  parameter int unsigned value_size = 32,
  parameter int unsigned row_w      = 16,
  parameter int unsigned depth      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [value_size-1:0]   psum,
  input  logic                    row_done,
  output logic                    in_ready,
  output logic                    adder_start,
  input  logic                    cfg_load,
  input  logic [row_w-1:0]        cfg_num_rows,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [row_w-1:0]        out_row,
  output logic [value_size-1:0]   out_data,
  output logic [$clog2(depth):0]  fifo_count,
  output logic                    done
);

  localparam int unsigned PtrW = $clog2(depth);

  typedef enum logic [1:0] {StIdle, StRun, StClear, StDone} state_e;

  state_e                state_q;
  logic [row_w-1:0]      num_rows_q;
  logic [row_w-1:0]      row_cnt_q;
  logic                  adder_start_q;
  logic                  done_q;

  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [PtrW:0]         count_q;
  logic [row_w-1:0]      row_mem  [depth];
  logic [value_size-1:0] data_mem [depth];

  logic full;
  logic accept;
  logic push;
  logic pop;
  logic skip;

`ifdef PSUM_ZERO_SKIP_EN
  // Sign bit ignored so that both +0 and -0 are skipped.
  assign skip = (psum[value_size-2:0] == '0);
`else
  assign skip = 1'b0;
`endif

  assign full      = (count_q == (PtrW+1)'(depth));
  assign in_ready  = (state_q == StRun) && !full;
  assign accept    = in_ready && row_done;
  assign push      = accept && !skip;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;

  assign adder_start = adder_start_q;
  assign done        = done_q;
  assign fifo_count  = count_q;
  assign out_row     = out_valid ? row_mem[rd_ptr_q]  : '0;
  assign out_data    = out_valid ? data_mem[rd_ptr_q] : '0;

  // Control FSM; adder_start is held high through reset to clear the adder stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      num_rows_q    <= '0;
      row_cnt_q     <= '0;
      adder_start_q <= 1'b1;
      done_q        <= 1'b0;
    end else begin
      adder_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cfg_load && (cfg_num_rows != '0)) begin
            num_rows_q <= cfg_num_rows;
            row_cnt_q  <= '0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          if (accept) begin
            adder_start_q <= 1'b1;
            state_q       <= StClear;
          end
        end
        StClear: begin
          if (row_cnt_q == (num_rows_q - row_w'(1))) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            row_cnt_q <= row_cnt_q + row_w'(1);
            state_q   <= StRun;
          end
        end
        StDone: begin
          if (count_q == '0) begin
            done_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + (PtrW+1)'(1);
      else if (pop && !push) count_q <= count_q - (PtrW+1)'(1);
    end
  end

  // Storage is not reset; outputs are gated by out_valid instead.
  always_ff @(posedge clk) begin
    if (push) begin
      row_mem[wr_ptr_q]  <= row_cnt_q;
      data_mem[wr_ptr_q] <= psum;
    end
  end

endmodule
